ps2_host_tx: RTL and testbench

Host-to-device PS/2 transmitter that sends one command byte to the keyboard, such as LED set 0xED or reset 0xFF. It performs the bus request (clock inhibit, then start bit), shifts 8 data bits LSB-first plus odd parity and stop on device-generated clocks, checks the device ACK, and reports done or error. It sits beside the existing PS/2 receive path and drives the shared open-drain ps2_clk/ps2_data lines through output-enable signals. tx_busy lets the receive path ignore bus activity during a transmission.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_sync_edge.sv | 35 +++
 rtl/ps2_host_tx.sv | 197 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, command bytes and the
// odd-parity helper used when a command byte is latched.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // Odd parity: the 9-bit word {parity, data} always holds an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for the raw PS/2 clock and data lines plus a
// falling-edge detect on the synchronized clock. Reusable by the receive path.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_clk_raw,
  input  logic i_data_raw,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_clk_fall
);

  logic [1:0] r_clk_ff;
  logic [1:0] r_data_ff;
  logic       r_clk_prev;

  // Synchronizer chains and previous-clock register; reset to the idle-high
  // bus level so leaving reset never looks like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_ff   <= 2'b11;
      r_data_ff  <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_ff   <= {r_clk_ff[0], i_clk_raw};
      r_data_ff  <= {r_data_ff[0], i_data_raw};
      r_clk_prev <= r_clk_ff[1];
    end
  end

  assign o_clk_sync  = r_clk_ff[1];
  assign o_data_sync = r_data_ff[1];
  assign o_clk_fall  = r_clk_prev & ~r_clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: requests the bus (clock inhibit, start
// bit), shifts 8 data bits LSB-first, odd parity and stop on device clocks,
// checks the device ACK and reports done or error. Lines are open-drain and
// driven through output enables (1 = pull low).
//
// Handshake: tx_valid/tx_ready. A byte is accepted on a rising clk edge where
// tx_valid && tx_ready; tx_ready is high only while idle, tx_data is latched
// on accept, and tx_valid is ignored at every other time.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    tx_data,
  input  logic          tx_valid,
  output logic          tx_ready,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          tx_error,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe,
  output ps2_tx_state_t dbg_state
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic w_clk_sync;
  logic w_data_sync;
  logic w_clk_fall;

  ps2_sync_edge u_sync (
    .clk         (clk),
    .rst         (rst),
    .i_clk_raw   (ps2_clk_in),
    .i_data_raw  (ps2_data_in),
    .o_clk_sync  (w_clk_sync),
    .o_data_sync (w_data_sync),
    .o_clk_fall  (w_clk_fall)
  );

  ps2_tx_state_t r_state, w_state_d;
  logic [IW-1:0] r_inh_cnt, w_inh_cnt_d;
  logic [TW-1:0] r_to_cnt, w_to_cnt_d;
  logic [3:0]    r_bit_cnt, w_bit_cnt_d;
  logic [8:0]    r_shift, w_shift_d;     // {parity, data}; refilled with 1s
  logic          r_clk_oe, w_clk_oe_d;
  logic          r_data_oe, w_data_oe_d;
  logic          r_done, w_done_d;
  logic          r_error, w_error_d;
  logic          r_tx_ready, r_tx_busy;

  // State, counters, shift register and all outputs registered together so
  // every output changes on the same edge as the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_inh_cnt  <= '0;
      r_to_cnt   <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_clk_oe   <= 1'b0;
      r_data_oe  <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_tx_ready <= 1'b1;
      r_tx_busy  <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_inh_cnt  <= w_inh_cnt_d;
      r_to_cnt   <= w_to_cnt_d;
      r_bit_cnt  <= w_bit_cnt_d;
      r_shift    <= w_shift_d;
      r_clk_oe   <= w_clk_oe_d;
      r_data_oe  <= w_data_oe_d;
      r_done     <= w_done_d;
      r_error    <= w_error_d;
      r_tx_ready <= (w_state_d == IDLE);
      r_tx_busy  <= (w_state_d != IDLE);
    end
  end

  // Next-state and next-output logic; timeout is checked before any edge so
  // it wins over a coincident falling clock.
  always_comb begin
    w_state_d   = r_state;
    w_inh_cnt_d = r_inh_cnt;
    w_to_cnt_d  = r_to_cnt;
    w_bit_cnt_d = r_bit_cnt;
    w_shift_d   = r_shift;
    w_clk_oe_d  = 1'b0;
    w_data_oe_d = 1'b0;
    w_done_d    = 1'b0;
    w_error_d   = 1'b0;

    case (r_state)
      IDLE: begin
        if (tx_valid && r_tx_ready) begin
          w_shift_d   = {ps2_odd_parity(tx_data), tx_data};
          w_inh_cnt_d = '0;
          w_bit_cnt_d = '0;
          w_clk_oe_d  = 1'b1;
          w_state_d   = INHIBIT;
        end
      end

      INHIBIT: begin
        w_clk_oe_d = 1'b1;
        if (r_inh_cnt == INH_LAST) begin
          w_data_oe_d = 1'b1;
          w_state_d   = START;
        end else begin
          w_inh_cnt_d = r_inh_cnt + 1'b1;
        end
      end

      START: begin
        // Release the clock, keep data low as the start bit.
        w_data_oe_d = 1'b1;
        w_to_cnt_d  = '0;
        w_bit_cnt_d = '0;
        w_state_d   = SHIFT;
      end

      SHIFT: begin
        w_data_oe_d = r_data_oe;
        if (r_to_cnt == TO_LAST) begin
          w_data_oe_d = 1'b0;
          w_error_d   = 1'b1;
          w_state_d   = IDLE;
        end else begin
          w_to_cnt_d = r_to_cnt + 1'b1;
          if (w_clk_fall) begin
            // Falls 1-9 present data then parity; fall 10 sees the 1s shifted
            // in behind them and so releases the line for the stop bit.
            w_data_oe_d = ~r_shift[0];
            w_shift_d   = {1'b1, r_shift[8:1]};
            w_bit_cnt_d = r_bit_cnt + 1'b1;
            if (r_bit_cnt == 4'd9) begin
              w_state_d = ACK;
            end
          end
        end
      end

      ACK: begin
        if (r_to_cnt == TO_LAST) begin
          w_error_d = 1'b1;
          w_state_d = IDLE;
        end else begin
          w_to_cnt_d = r_to_cnt + 1'b1;
          if (w_clk_fall) begin
            if (!w_data_sync) begin
              w_state_d = WAIT_IDLE;
            end else begin
              w_error_d = 1'b1;
              w_state_d = IDLE;
            end
          end
        end
      end

      WAIT_IDLE: begin
        if (r_to_cnt == TO_LAST) begin
          w_error_d = 1'b1;
          w_state_d = IDLE;
        end else begin
          w_to_cnt_d = r_to_cnt + 1'b1;
          if (w_clk_sync && w_data_sync) begin
            w_done_d  = 1'b1;
            w_state_d = IDLE;
          end
        end
      end

      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  assign tx_ready    = r_tx_ready;
  assign tx_busy     = r_tx_busy;
  assign tx_done     = r_done;
  assign tx_error    = r_error;
  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_data_oe = r_data_oe;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus and a small device
// model that clocks the frame, samples each bit and optionally ACKs.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 40;
  localparam int TO   = 4000;
  localparam int HALF = 20;

  logic          clk;
  logic          rst;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          tx_busy;
  logic          tx_done;
  logic          tx_error;
  logic          ps2_clk_in;
  logic          ps2_data_in;
  logic          ps2_clk_oe;
  logic          ps2_data_oe;
  ps2_tx_state_t dbg_state;

  logic dev_clk_low;
  logic dev_data_low;

  int checks;
  int errors;
  int done_seen;
  int err_seen;

  // Wired-AND open-drain bus: either side pulling low wins.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .dbg_state   (dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor: counts every sampled cycle with done/error high.
  always @(negedge clk) begin
    if (tx_done)  done_seen++;
    if (tx_error) err_seen++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept a byte and verify the bus-request timing up to the first SHIFT cycle.
  task automatic request(input logic [7:0] d);
    int n;
    @(negedge clk);
    check("ready_before_accept", 32'(tx_ready), 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;
    check("busy_after_accept", 32'(tx_busy), 1);
    n = 0;
    while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin
      n++;
      @(negedge clk);
    end
    check("inhibit_cycles", 32'(n), 32'(INH));
    n = 0;
    while (ps2_clk_oe && ps2_data_oe && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("start_cycles", 32'(n), 1);
    check("shift_clk_oe", 32'(ps2_clk_oe), 0);
    check("shift_data_oe", 32'(ps2_data_oe), 1);
  endtask

  // Device: give nclk clocks, sampling the data line just before each fall.
  task automatic dev_xfer(input int nclk, input bit ack, output logic [10:0] bits);
    int n;
    bits = '0;
    n = 0;
    while (!(ps2_clk_in && !ps2_data_in) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("dev_sees_request", 32'(n < 200), 1);
    for (int k = 0; k < nclk; k++) begin
      repeat (HALF) @(negedge clk);
      bits[k] = ps2_data_in;
      if (k == 10 && ack) begin
        dev_data_low = 1'b1;
        repeat (4) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  initial begin
    int d0, e0, n;
    logic [10:0] bits;
    checks       = 0;
    errors       = 0;
    done_seen    = 0;
    err_seen     = 0;
    rst          = 1'b1;
    tx_data      = 8'h00;
    tx_valid     = 1'b0;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_ready", 32'(tx_ready), 1);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_done", 32'(tx_done), 0);
    check("rst_error", 32'(tx_error), 0);
    check("rst_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_data_oe", 32'(ps2_data_oe), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // 0xED with ACK; a second request while busy must be ignored.
    d0 = done_seen; e0 = err_seen;
    request(PS2_CMD_SET_LEDS);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    repeat (10) @(negedge clk);
    check("ready_low_while_busy", 32'(tx_ready), 0);
    tx_valid = 1'b0;
    dev_xfer(11, 1'b1, bits);
    repeat (10) @(negedge clk);
    // stop=1, parity=1 (six ones), 0xED, start=0 -> 0x7DA
    check("ed_frame", 32'(bits), 32'h7DA);
    check("ed_done_pulses", 32'(done_seen - d0), 1);
    check("ed_error_pulses", 32'(err_seen - e0), 0);
    check("ed_clk_oe_after", 32'(ps2_clk_oe), 0);
    check("ed_data_oe_after", 32'(ps2_data_oe), 0);
    check("ed_state_after", 32'(dbg_state), 32'(IDLE));

    // 0x01 -> parity 0: frame 0x402
    d0 = done_seen; e0 = err_seen;
    request(8'h01);
    dev_xfer(11, 1'b1, bits);
    repeat (10) @(negedge clk);
    check("x01_frame", 32'(bits), 32'h402);
    check("x01_done_pulses", 32'(done_seen - d0), 1);

    // 0x00 -> parity 1: frame 0x600
    d0 = done_seen; e0 = err_seen;
    request(8'h00);
    dev_xfer(11, 1'b1, bits);
    repeat (10) @(negedge clk);
    check("x00_frame", 32'(bits), 32'h600);
    check("x00_done_pulses", 32'(done_seen - d0), 1);
    check("x00_error_pulses", 32'(err_seen - e0), 0);

    // 0xFF with no ACK: error pulse, no done. Frame 0x7FE.
    d0 = done_seen; e0 = err_seen;
    request(PS2_CMD_RESET);
    dev_xfer(11, 1'b0, bits);
    repeat (10) @(negedge clk);
    check("nack_frame", 32'(bits), 32'h7FE);
    check("nack_error_pulses", 32'(err_seen - e0), 1);
    check("nack_done_pulses", 32'(done_seen - d0), 0);
    check("nack_state", 32'(dbg_state), 32'(IDLE));
    check("nack_ready", 32'(tx_ready), 1);
    check("nack_data_oe", 32'(ps2_data_oe), 0);

    // Silent device: error exactly TO cycles after the first SHIFT cycle.
    d0 = done_seen; e0 = err_seen;
    request(PS2_RESP_ACK);
    n = 0;
    while (!tx_error && n < TO + 100) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 32'(n), 32'(TO));
    check("timeout_clk_oe", 32'(ps2_clk_oe), 0);
    check("timeout_data_oe", 32'(ps2_data_oe), 0);
    @(negedge clk);
    check("timeout_pulse_width", 32'(err_seen - e0), 1);
    check("timeout_no_done", 32'(done_seen - d0), 0);
    check("timeout_ready", 32'(tx_ready), 1);

    // Reset during bit 4 of 0xA5 (bit 3 = 0, so data is pulled low).
    d0 = done_seen; e0 = err_seen;
    request(8'hA5);
    dev_xfer(4, 1'b0, bits);
    repeat (2) @(negedge clk);
    check("bit4_data_oe", 32'(ps2_data_oe), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_data_oe", 32'(ps2_data_oe), 0);
    check("rst_mid_clk_oe", 32'(ps2_clk_oe), 0);
    check("rst_mid_busy", 32'(tx_busy), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_mid_no_pulses", 32'((done_seen - d0) + (err_seen - e0)), 0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));

    // Reset during clock inhibit releases the clock line immediately.
    @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("inhibit_clk_oe", 32'(ps2_clk_oe), 1);
    #2 rst = 1'b1;
    #1;
    check("rst_inh_clk_oe", 32'(ps2_clk_oe), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_inh_ready", 32'(tx_ready), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
